// File: rtl/maxpool_2x2.sv
`default_nettype none
// ============================================================================
// maxpool_2x2 : streaming 2x2 / stride-2 max-pool over packed channels.
//   Optional macro MAXPOOL_SIGNED_CMP_EN selects two's-complement compare.
// Revision 1.0
// ============================================================================
module maxpool_2x2 #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_CHANNEL = 4,
  parameter int IN_WIDTH   = 8,
  parameter int IN_HEIGHT  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*IN_CHANNEL-1:0] i_data,
  input  logic                             i_valid,
  output logic [DATA_WIDTH*IN_CHANNEL-1:0] o_data,
  output logic                             o_valid,
  output logic                             o_frame_done
);

  localparam int PIX_W  = DATA_WIDTH * IN_CHANNEL;
  localparam int HALF_W = IN_WIDTH / 2;
  localparam int COL_W  = $clog2(IN_WIDTH + 1);
  localparam int ROW_W  = $clog2(IN_HEIGHT + 1);
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ACT  = COL_W'(2 * (IN_WIDTH / 2));
  localparam logic [ROW_W-1:0] ROW_ACT  = ROW_W'(2 * (IN_HEIGHT / 2));
  localparam logic [COL_W-1:0] COL_FIN  = COL_W'(2 * (IN_WIDTH / 2) - 1);
  localparam logic [ROW_W-1:0] ROW_FIN  = ROW_W'(2 * (IN_HEIGHT / 2) - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] h_reg;
  logic [PIX_W-1:0] rowbuf [HALF_W];
  logic [IDX_W-1:0] buf_idx;
  logic [PIX_W-1:0] rd_pix;
  logic [PIX_W-1:0] max_hin;
  logic [PIX_W-1:0] max_win;
  logic             in_active;
  logic             buf_we;

  function automatic logic el_gt(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
`ifdef MAXPOOL_SIGNED_CMP_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Trailing odd column/row is counted but never enters a window.
  assign in_active = (col < COL_ACT) && (row < ROW_ACT);
  assign buf_idx   = col[IDX_W:1];
  assign rd_pix    = rowbuf[buf_idx];
  assign buf_we    = rst_n && i_valid && in_active && col[0] && !row[0];

  for (genvar c = 0; c < IN_CHANNEL; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] in_el;
    logic [DATA_WIDTH-1:0] h_el;
    logic [DATA_WIDTH-1:0] rd_el;
    logic [DATA_WIDTH-1:0] hin_el;
    assign in_el  = i_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign h_el   = h_reg[c*DATA_WIDTH +: DATA_WIDTH];
    assign rd_el  = rd_pix[c*DATA_WIDTH +: DATA_WIDTH];
    assign hin_el = el_gt(h_el, in_el) ? h_el : in_el;
    assign max_hin[c*DATA_WIDTH +: DATA_WIDTH] = hin_el;
    assign max_win[c*DATA_WIDTH +: DATA_WIDTH] = el_gt(rd_el, hin_el) ? rd_el : hin_el;
  end

  // Row buffer holds top-row pair maxima; written before read, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      rowbuf[buf_idx] <= max_hin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      h_reg        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (in_active) begin
          if (!col[0]) begin
            h_reg <= i_data;
          end else if (row[0]) begin
            o_data       <= max_win;
            o_valid      <= 1'b1;
            o_frame_done <= (row == ROW_FIN) && (col == COL_FIN);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
